// File: rtl/btb_pkg.sv
// Shared types and counter encodings for the branch target buffer.
package btb_pkg;

  typedef enum logic {IDLE, FLUSH} btb_state_t;

  localparam logic [1:0] CTR_STRONG_NT = 2'd0;
  localparam logic [1:0] CTR_WEAK_NT   = 2'd1;
  localparam logic [1:0] CTR_WEAK_T    = 2'd2;
  localparam logic [1:0] CTR_STRONG_T  = 2'd3;

endpackage

// File: rtl/btb_sat_ctr.sv
// Combinational 2-bit saturating direction counter step.
module btb_sat_ctr
  import btb_pkg::*;
(
  input  logic [1:0] cur_i,
  input  logic       taken_i,
  output logic [1:0] next_o
);

  always_comb begin
    next_o = cur_i;
    if (taken_i) begin
      if (cur_i != CTR_STRONG_T) next_o = cur_i + 2'd1;
    end else begin
      if (cur_i != CTR_STRONG_NT) next_o = cur_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit direction counters and a sequential invalidate engine.
// Optional statistics counters are enabled with the BTB_STATS_EN macro.
module branch_target_buffer
  import btb_pkg::*;
#(
  parameter int unsigned  ENTRIES = 16,
  localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        lookup_valid,
  input  logic [31:0] lookup_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        flush_req,
  output logic        busy
`ifdef BTB_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] lookup_count
`endif
);

  localparam int unsigned TAG_W = 30 - IDX_W;

  logic [ENTRIES-1:0]      valid_q, valid_d;
  logic [ENTRIES-1:0][1:0] ctr_q, ctr_d;
  logic [TAG_W-1:0]        tag_q    [ENTRIES];
  logic [31:0]             target_q [ENTRIES];
  btb_state_t              state_q, state_d;
  logic [IDX_W-1:0]        flush_idx_q, flush_idx_d;

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             up_hit, upd_fire;
  logic [1:0]       ctr_next;
  logic             unused_pc_bits;

  assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0], lookup_valid};

  // Lookup path: purely combinational from registered state.
  assign lk_idx      = lookup_pc[IDX_W+1:2];
  assign lk_tag      = lookup_pc[31:IDX_W+2];
  assign pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag) && (state_q == IDLE);
  assign pred_taken  = pred_hit && ctr_q[lk_idx][1];
  assign pred_target = pred_hit ? target_q[lk_idx] : 32'd0;

  assign upd_ready = (state_q == IDLE);
  assign busy      = (state_q == FLUSH);
  assign upd_fire  = upd_valid && upd_ready;
  assign up_idx    = upd_pc[IDX_W+1:2];
  assign up_tag    = upd_pc[31:IDX_W+2];
  assign up_hit    = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  btb_sat_ctr u_sat_ctr (
    .cur_i   (ctr_q[up_idx]),
    .taken_i (upd_taken),
    .next_o  (ctr_next)
  );

  always_comb begin
    valid_d     = valid_q;
    ctr_d       = ctr_q;
    state_d     = state_q;
    flush_idx_d = flush_idx_q;
    unique case (state_q)
      IDLE: begin
        if (upd_fire) begin
          if (up_hit) begin
            ctr_d[up_idx] = ctr_next;
          end else if (upd_taken) begin
            valid_d[up_idx] = 1'b1;
            ctr_d[up_idx]   = CTR_WEAK_T;
          end
        end
        if (flush_req) begin
          state_d     = FLUSH;
          flush_idx_d = '0;
        end
      end
      FLUSH: begin
        valid_d[flush_idx_q] = 1'b0;
        flush_idx_d          = flush_idx_q + 1'b1;
        if (flush_idx_q == IDX_W'(ENTRIES - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      valid_q     <= '0;
      ctr_q       <= '0;
      state_q     <= IDLE;
      flush_idx_q <= '0;
    end else begin
      valid_q     <= valid_d;
      ctr_q       <= ctr_d;
      state_q     <= state_d;
      flush_idx_q <= flush_idx_d;
    end
  end

  // Tag and target carry no reset; valid gates every use of them.
  always_ff @(posedge CLK) begin
    if (upd_fire && upd_taken) begin
      tag_q[up_idx]    <= up_tag;
      target_q[up_idx] <= upd_target;
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] hit_cnt_q, lk_cnt_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hit_cnt_q <= '0;
      lk_cnt_q  <= '0;
    end else if (lookup_valid && (state_q == IDLE)) begin
      lk_cnt_q <= lk_cnt_q + 32'd1;
      if (pred_hit) hit_cnt_q <= hit_cnt_q + 32'd1;
    end
  end

  assign hit_count    = hit_cnt_q;
  assign lookup_count = lk_cnt_q;
`endif

endmodule
